// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared sizes and phase encoding for the register file
// Contents:
//   DATA_W, NREG, NPHASE : default register width, register count, phases per instruction
//   ADDR_W, PHASE_W      : address and phase-bus widths
//   phase_e              : named phases PH_FETCH..PH_WB (0..4)
package reg_file_pkg;

    localparam int DATA_W  = 16;
    localparam int NREG    = 8;
    localparam int NPHASE  = 5;
    localparam int ADDR_W  = 3;
    localparam int PHASE_W = 3;

    typedef enum logic [PHASE_W-1:0] {
        PH_FETCH = 3'd0,
        PH_READ  = 3'd1,
        PH_EXEC  = 3'd2,
        PH_MEM   = 3'd3,
        PH_WB    = 3'd4
    } phase_e;

endpackage

// File: rtl/reg_file_phase_counter.sv
// rtl/reg_file_phase_counter.sv - instruction phase sequencer 0..NPHASE-1 with halt
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, forces phase to 0
//   halt    : holds the current phase while high
//   phase   : current phase
import reg_file_pkg::*;

module phase_counter #(
    parameter int NPHASE = reg_file_pkg::NPHASE
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               halt,
    output logic [PHASE_W-1:0] phase
);

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;

    always_comb begin
        phase_d = phase_q;
        if (!halt) begin
            if (phase_q == PHASE_W'(NPHASE - 1)) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - phase-sequenced register file, two registered read ports, one write port
// Ports:
//   clock, reset_n          : rising-edge clock, asynchronous active-low reset
//   halt                    : freezes the phase counter and blocks reads and writes
//   read_add_a, read_add_b  : source register addresses, captured at the read phase
//   write_add, writeOrder   : destination register and write enable, applied at write-back
//   write_data              : write-back value
//   phase                   : current instruction phase
//   read_data_a, read_data_b: registered read results
import reg_file_pkg::*;

module reg_file #(
    parameter int DATA_W = reg_file_pkg::DATA_W,
    parameter int NREG   = reg_file_pkg::NREG,
    parameter int NPHASE = reg_file_pkg::NPHASE
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               halt,
    input  logic [ADDR_W-1:0]  read_add_a,
    input  logic [ADDR_W-1:0]  read_add_b,
    input  logic [ADDR_W-1:0]  write_add,
    input  logic               writeOrder,
    input  logic [DATA_W-1:0]  write_data,
    output logic [PHASE_W-1:0] phase,
    output logic [DATA_W-1:0]  read_data_a,
    output logic [DATA_W-1:0]  read_data_b
);

    logic [PHASE_W-1:0] phase_w;

    phase_counter #(
        .NPHASE (NPHASE)
    ) u_phase_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .halt    (halt),
        .phase   (phase_w)
    );

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [DATA_W-1:0] rda_q;
    logic [DATA_W-1:0] rda_d;
    logic [DATA_W-1:0] rdb_q;
    logic [DATA_W-1:0] rdb_d;

    logic rd_en;
    logic wr_en;

    // Reads and writes live in different phases, so a read never sees a
    // same-edge write and no bypass path is needed.
    assign rd_en = !halt && (phase_w == PH_READ);
    assign wr_en = !halt && writeOrder && (phase_w == PH_WB);

    always_comb begin
        regs_d = regs_q;
        rda_d  = rda_q;
        rdb_d  = rdb_q;
        if (wr_en) begin
            regs_d[write_add] = write_data;
        end
        if (rd_en) begin
            rda_d = regs_q[read_add_a];
            rdb_d = regs_q[read_add_b];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            rda_q <= '0;
            rdb_q <= '0;
        end else begin
            regs_q <= regs_d;
            rda_q  <= rda_d;
            rdb_q  <= rdb_d;
        end
    end

    assign phase       = phase_w;
    assign read_data_a = rda_q;
    assign read_data_b = rdb_q;

endmodule
